fp8_int_encoder: RTL

- Sequential encoder that converts an 8-bit integer into the team's 8-bit minifloat format. The format is sign[7], exponent[6:3] with bias 7, and mantissa[2:0] with a hidden leading 1.
- 0x00 encodes zero. Exponent 15 with mantissa 000 encodes infinity.
- Sits upstream of the fp8 adder, producing operands from integer sources.
- Normalizes one bit per clock; rounds to nearest, ties to even.
- Valid/ready handshakes on both the input and output sides.

---
 rtl/fp8_int_encoder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fp8_int_encoder.sv
// Purpose: converts an 8-bit signed/unsigned integer into the sign/exp4(bias 7)/mant3 minifloat, RNE rounding.
// Latency: result held 2 + leading-zeros(mag) cycles after acceptance (zero input: presented right after acceptance).
// Backpressure: result parks in HOLD until out_ready; no new input is accepted until the result is consumed.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   ena                 freeze control; 0 holds all state and masks in_ready/out_valid
//   in_valid/in_ready   input handshake for in_data/in_signed
//   in_data, in_signed  integer to encode; in_signed selects two's-complement interpretation
//   out_valid/out_ready output handshake for out_data/out_inexact
//   out_data            encoded minifloat
//   out_inexact         rounding discarded nonzero bits or the result saturated to infinity

module fp8_int_encoder #(
  parameter int BIAS = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_signed,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_inexact
);

  // An 8-bit magnitude with its MSB set has unbiased exponent 7.
  localparam logic [3:0] EXP_START = 4'(BIAS + 7);

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_ROUND,
    S_HOLD
  } state_t;

  state_t     r_state;
  logic       r_sgn;
  logic [7:0] r_mag;
  logic [3:0] r_exp;
  logic [7:0] r_out_data;
  logic       r_out_inexact;

  logic       w_sgn;
  logic [7:0] w_mag;
  logic [2:0] w_mant;
  logic       w_guard;
  logic       w_sticky;
  logic       w_round_up;
  logic [3:0] w_mant_sum;
  logic [3:0] w_exp_rnd;
  logic [2:0] w_mant_rnd;
  logic [7:0] w_result;

  // Input capture: -128 negates to itself, which is exactly the magnitude 0x80 we want.
  assign w_sgn = in_signed & in_data[7];
  assign w_mag = w_sgn ? 8'(8'd0 - in_data) : in_data;

  // Round-to-nearest-even on the normalized magnitude (hidden bit is r_mag[7]).
  assign w_mant     = r_mag[6:4];
  assign w_guard    = r_mag[3];
  assign w_sticky   = |r_mag[2:0];
  assign w_round_up = w_guard & (w_sticky | w_mant[0]);
  assign w_mant_sum = {1'b0, w_mant} + {3'b000, w_round_up};
  assign w_exp_rnd  = r_exp + {3'b000, w_mant_sum[3]};
  assign w_mant_rnd = w_mant_sum[3] ? 3'b000 : w_mant_sum[2:0];

  // Exponent 15 only arises from a rounding carry, so this is the infinity encoding.
  assign w_result = (w_exp_rnd == 4'hF) ? {r_sgn, 4'hF, 3'b000}
                                        : {r_sgn, w_exp_rnd, w_mant_rnd};

  // Gated by rst_n so the block advertises nothing while held in reset.
  assign in_ready    = rst_n & ena & (r_state == S_IDLE);
  assign out_valid   = ena & (r_state == S_HOLD);
  assign out_data    = r_out_data;
  assign out_inexact = r_out_inexact;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_sgn         <= 1'b0;
      r_mag         <= 8'h00;
      r_exp         <= 4'h0;
      r_out_data    <= 8'h00;
      r_out_inexact <= 1'b0;
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sgn <= w_sgn;
            r_mag <= w_mag;
            r_exp <= EXP_START;
            if (w_mag == 8'h00) begin
              r_out_data    <= 8'h00;
              r_out_inexact <= 1'b0;
              r_state       <= S_HOLD;
            end else begin
              r_state <= S_NORM;
            end
          end
        end
        S_NORM: begin
          // One shift per cycle; mag is nonzero here so this terminates within 7 shifts.
          if (r_mag[7]) begin
            r_state <= S_ROUND;
          end else begin
            r_mag <= {r_mag[6:0], 1'b0};
            r_exp <= r_exp - 4'd1;
          end
        end
        S_ROUND: begin
          r_out_data    <= w_result;
          r_out_inexact <= w_guard | w_sticky;
          r_state       <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
